// File: rtl/regfile_mp.sv
// Multi-port register file for the pipelined ARM core: NUM_RD combinational read ports,
// two write ports (port 1 wins on collision), PC slot, per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3,
  parameter int PC_IDX = 15
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] RD,
  output logic [NUM_RD-1:0]        RBUSY,
  input  logic [DATA_W-1:0]        PC_IN,
  input  logic                     WE0,
  input  logic [ADDR_W-1:0]        WA0,
  input  logic [DATA_W-1:0]        WD0,
  input  logic                     WE1,
  input  logic [ADDR_W-1:0]        WA1,
  input  logic [DATA_W-1:0]        WD1,
  input  logic                     ISS_EN,
  input  logic [ADDR_W-1:0]        ISS_A,
  output logic                     WCOLL
);

  localparam int                NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic              w_we0_ok;
  logic              w_we1_ok;
  logic              w_iss_ok;
  logic [DATA_W-1:0] w_store [NREG];
  logic [NREG-1:0]   w_busy;
  logic              r_wcoll;

  // Writes and issues that target the PC slot are simply dropped.
  assign w_we0_ok = WE0 && (WA0 != PC_A);
  assign w_we1_ok = WE1 && (WA1 != PC_A);
  assign w_iss_ok = ISS_EN && (ISS_A != PC_A);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == PC_IDX) begin : g_pc
        assign w_store[gi] = '0;
        assign w_busy[gi]  = 1'b0;
      end else begin : g_slot
        localparam logic [ADDR_W-1:0] SLOT_A = ADDR_W'(gi);
        logic [DATA_W-1:0] r_data;
        logic              r_busy;
        logic              w_hit0;
        logic              w_hit1;

        assign w_hit0 = w_we0_ok && (WA0 == SLOT_A);
        assign w_hit1 = w_we1_ok && (WA1 == SLOT_A);

        always_ff @(posedge clk or negedge Reset) begin
          if (!Reset) begin
            r_data <= '0;
            r_busy <= 1'b0;
          end else begin
            if (w_hit1)
              r_data <= WD1;
            else if (w_hit0)
              r_data <= WD0;
            // A new issue outranks a retiring write: the new producer is still pending.
            if (w_iss_ok && (ISS_A == SLOT_A))
              r_busy <= 1'b1;
            else if (w_hit0 || w_hit1)
              r_busy <= 1'b0;
          end
        end

        assign w_store[gi] = r_data;
        assign w_busy[gi]  = r_busy;
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;
      logic              w_rbusy;

      assign w_ra = RA[gi*ADDR_W +: ADDR_W];

      always_comb begin
        w_rd    = (w_ra == PC_A) ? PC_IN : w_store[w_ra];
        w_rbusy = w_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
        if (w_we1_ok && (WA1 == w_ra)) begin
          w_rd    = WD1;
          w_rbusy = 1'b0;
        end else if (w_we0_ok && (WA0 == w_ra)) begin
          w_rd    = WD0;
          w_rbusy = 1'b0;
        end
`endif
      end

      assign RD[gi*DATA_W +: DATA_W] = w_rd;
      assign RBUSY[gi]               = w_rbusy;
    end
  endgenerate

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)
      r_wcoll <= 1'b0;
    else
      r_wcoll <= WE0 && WE1 && (WA0 == WA1);
  end

  assign WCOLL = r_wcoll;

endmodule
